// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: per-button sync/debounce/edge-detect feeding the
// idle/run/pause/lap FSM that drives counter enable/clear and display hold.
//
// state | meaning
// IDLE  | stopped, count cleared or untouched since reset
// RUN   | counting, display live
// PAUSE | stopped, count preserved
// LAP   | counting, display frozen on lap value
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_W            = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       count_en,
    output logic       count_clr,
    output logic       disp_hold,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    // bit 0 start_stop, bit 1 lap, bit 2 clear
    logic [2:0] raw;
    logic [2:0] press;

    assign raw = {btn_clear, btn_lap, btn_start_stop};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic            sync1;
        logic            sync2;
        logic            stable;
        logic            stable_d;
        logic            pulse;
        logic [DB_W-1:0] cnt;

        // The press pulse is registered so every output is one flop away
        // from an accepted level change.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1    <= 1'b0;
                sync2    <= 1'b0;
                stable   <= 1'b0;
                stable_d <= 1'b0;
                pulse    <= 1'b0;
                cnt      <= '0;
            end else begin
                sync1    <= raw[g];
                sync2    <= sync1;
                stable_d <= stable;
                pulse    <= stable & ~stable_d;
                if (sync2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + DB_W'(1);
                end
            end
        end

        assign press[g] = pulse;
    end

    state_t state_q;
    state_t state_n;
    logic   clr_n;

    // Only the highest-priority event is consumed each cycle, even if the
    // current state ignores it.
    always_comb begin
        state_n = state_q;
        clr_n   = 1'b0;
        if (press[2]) begin
            if (state_q == IDLE || state_q == PAUSE) begin
                state_n = IDLE;
                clr_n   = 1'b1;
            end
        end else if (press[0]) begin
            case (state_q)
                IDLE:    state_n = RUN;
                RUN:     state_n = PAUSE;
                LAP:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                default: state_n = IDLE;
            endcase
        end else if (press[1]) begin
            if (state_q == RUN) begin
                state_n = LAP;
            end else if (state_q == LAP) begin
                state_n = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_en  <= 1'b0;
            count_clr <= 1'b0;
            disp_hold <= 1'b0;
        end else begin
            state_q   <= state_n;
            count_en  <= (state_n == RUN) || (state_n == LAP);
            count_clr <= clr_n;
            disp_hold <= (state_n == LAP);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window
// (DEBOUNCE_CYCLES=4); expected values are hand-computed.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start_stop = 1'b0;
    logic       btn_lap = 1'b1;
    logic       btn_clear = 1'b1;
    logic       count_en;
    logic       count_clr;
    logic       disp_hold;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int clr_seen;
    int run_seen;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .count_en       (count_en),
        .count_clr      (count_clr),
        .disp_hold      (disp_hold),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btn_start_stop = v;
            1: btn_lap = v;
            default: btn_clear = v;
        endcase
    endtask

    // Press long enough to be accepted, then release long enough to settle.
    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        cycles(10);
        set_btn(idx, 1'b0);
        cycles(10);
    endtask

    initial begin
        // 1: async reset before any clock edge, buttons at arbitrary levels
        #3 rst = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_en", 32'(count_en), 32'h0);
        chk("rst_hold", 32'(disp_hold), 32'h0);
        chk("rst_clr", 32'(count_clr), 32'h0);
        btn_lap = 1'b0;
        btn_clear = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(4);
        chk("post_rst_state", 32'(state), 32'h0);

        // 3: bouncing input never accepted
        for (int i = 0; i < 10; i++) begin
            btn_start_stop = ~btn_start_stop;
            cycles(2);
            chk("bounce_state", 32'(state), 32'h0);
        end
        btn_start_stop = 1'b0;
        cycles(10);
        chk("bounce_final_state", 32'(state), 32'h0);
        chk("bounce_final_en", 32'(count_en), 32'h0);

        // 2: held start_stop; first sampled at edge 0, state updates after edge 7
        btn_start_stop = 1'b1;
        cycles(7);
        chk("lat_before_state", 32'(state), 32'h0);
        chk("lat_before_en", 32'(count_en), 32'h0);
        cycles(1);
        chk("lat_state", 32'(state), 32'h1);
        chk("lat_en", 32'(count_en), 32'h1);
        cycles(4);
        chk("held_state", 32'(state), 32'h1);
        btn_start_stop = 1'b0;
        cycles(10);
        chk("release_state", 32'(state), 32'h1);
        chk("release_en", 32'(count_en), 32'h1);

        // 4: lap toggling and stop from lap
        press(1);
        chk("lap_state", 32'(state), 32'h3);
        chk("lap_hold", 32'(disp_hold), 32'h1);
        chk("lap_en", 32'(count_en), 32'h1);
        press(1);
        chk("unlap_state", 32'(state), 32'h1);
        chk("unlap_hold", 32'(disp_hold), 32'h0);
        press(1);
        chk("lap2_state", 32'(state), 32'h3);
        press(0);
        chk("lap_stop_state", 32'(state), 32'h2);
        chk("lap_stop_hold", 32'(disp_hold), 32'h0);
        chk("lap_stop_en", 32'(count_en), 32'h0);

        // 5: clear from PAUSE pulses count_clr for exactly one cycle
        btn_clear = 1'b1;
        cycles(7);
        chk("clr_before_pulse", 32'(count_clr), 32'h0);
        chk("clr_before_state", 32'(state), 32'h2);
        cycles(1);
        chk("clr_pulse", 32'(count_clr), 32'h1);
        chk("clr_state", 32'(state), 32'h0);
        cycles(1);
        chk("clr_pulse_end", 32'(count_clr), 32'h0);
        btn_clear = 1'b0;
        cycles(10);
        chk("clr_idle_state", 32'(state), 32'h0);

        // 5b: clear ignored while running
        press(0);
        chk("run_again_state", 32'(state), 32'h1);
        clr_seen = 0;
        btn_clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (count_clr === 1'b1) clr_seen++;
        end
        btn_clear = 1'b0;
        cycles(10);
        chk("run_clr_pulses", 32'(clr_seen), 32'h0);
        chk("run_clr_state", 32'(state), 32'h1);
        chk("run_clr_en", 32'(count_en), 32'h1);

        // 6: clear and start_stop accepted together in PAUSE: clear wins
        press(0);
        chk("pause_state", 32'(state), 32'h2);
        clr_seen = 0;
        run_seen = 0;
        btn_clear = 1'b1;
        btn_start_stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (count_clr === 1'b1) clr_seen++;
            if (state === 2'b01) run_seen++;
        end
        btn_clear = 1'b0;
        btn_start_stop = 1'b0;
        cycles(10);
        chk("prio_clr_pulses", 32'(clr_seen), 32'h1);
        chk("prio_run_seen", 32'(run_seen), 32'h0);
        chk("prio_state", 32'(state), 32'h0);

        // clear in IDLE still pulses count_clr
        clr_seen = 0;
        btn_clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (count_clr === 1'b1) clr_seen++;
        end
        btn_clear = 1'b0;
        cycles(10);
        chk("idle_clr_pulses", 32'(clr_seen), 32'h1);
        chk("idle_clr_state", 32'(state), 32'h0);

        // reset pulse while in LAP
        press(0);
        press(1);
        chk("pre_rst_state", 32'(state), 32'h3);
        chk("pre_rst_hold", 32'(disp_hold), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("lap_rst_state", 32'(state), 32'h0);
        chk("lap_rst_en", 32'(count_en), 32'h0);
        chk("lap_rst_hold", 32'(disp_hold), 32'h0);
        chk("lap_rst_clr", 32'(count_clr), 32'h0);
        cycles(2);
        rst = 1'b0;
        cycles(10);
        chk("after_rst_state", 32'(state), 32'h0);
        chk("after_rst_clr", 32'(count_clr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
